// File: rtl/fixed_matmul_tile_scheduler_if.sv
// Control, issue and retire signals between the matmul tile scheduler and its
// fetch unit / core wrapper. The scheduler takes the master side.
interface fixed_matmul_tile_scheduler_if #(
   parameter int CNT_W  = 8,
   parameter int ADDR_W = 16
);
   logic              start;
   logic [CNT_W-1:0]  cfg_n_tiles;
   logic [CNT_W-1:0]  cfg_k_tiles;
   logic              busy;
   logic              done;
   logic              issue_valid;
   logic              issue_ready;
   logic [ADDR_W-1:0] a_addr;
   logic [ADDR_W-1:0] b_addr;
   logic              issue_last;
   logic              out_fire;
   logic [ADDR_W-1:0] c_addr;

   modport master (
      input  start, cfg_n_tiles, cfg_k_tiles, issue_ready, out_fire,
      output busy, done, issue_valid, a_addr, b_addr, issue_last, c_addr
   );

   modport slave (
      output start, cfg_n_tiles, cfg_k_tiles, issue_ready, out_fire,
      input  busy, done, issue_valid, a_addr, b_addr, issue_last, c_addr
   );
endinterface

// File: rtl/fixed_matmul_tile_scheduler.sv
// Walks a tiled matrix product (m innermost, then k, then n), issuing one
// (A-tile, B-tile) address pair per core beat and tagging retired C tiles.
module fixed_matmul_tile_scheduler #(
   parameter int DEPTH   = 3,
   parameter int CNT_W   = 8,
   parameter int ADDR_W  = 16,
   parameter int MAX_OUT = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   fixed_matmul_tile_scheduler_if.master bus
);
   localparam int M_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int O_W = $clog2(MAX_OUT + 1);
   localparam logic [M_W-1:0]    M_LAST = M_W'(DEPTH - 1);
   localparam logic [O_W-1:0]    O_MAX  = O_W'(MAX_OUT);
   localparam logic [ADDR_W-1:0] A_STEP = ADDR_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  n_tiles, k_tiles;
   logic [M_W-1:0]    m_cnt;
   logic [CNT_W-1:0]  k_cnt, n_cnt;
   logic [ADDR_W-1:0] a_base, a_addr, b_addr, c_addr;
   logic [O_W-1:0]    outstanding, outstanding_nxt;
   logic              issue_valid, fire, tile_issued, retire;
   logic              m_wrap, k_wrap, n_wrap, start_ok, cfg_empty;

   assign m_wrap      = (m_cnt == M_LAST);
   assign k_wrap      = (k_cnt == k_tiles - CNT_W'(1));
   assign n_wrap      = (n_cnt == n_tiles - CNT_W'(1));
   assign start_ok    = (state == IDLE) && bus.start;
   assign cfg_empty   = (bus.cfg_n_tiles == '0) || (bus.cfg_k_tiles == '0);

   // A new output tile may only begin once a store slot is guaranteed for it.
   assign issue_valid = (state == ISSUE) && !((m_cnt == '0) && (outstanding == O_MAX));
   assign fire        = issue_valid && bus.issue_ready;
   assign tile_issued = fire && m_wrap;
   assign retire      = bus.out_fire && (outstanding != '0);

   assign bus.issue_valid = issue_valid;
   assign bus.issue_last  = issue_valid && m_wrap;
   assign bus.a_addr      = a_addr;
   assign bus.b_addr      = b_addr;
   assign bus.c_addr      = c_addr;
   assign bus.busy        = (state != IDLE);
   assign bus.done        = (state == FINISH);

   always_comb begin
      outstanding_nxt = outstanding;
      if (tile_issued && !retire) begin
         outstanding_nxt = outstanding + O_W'(1);
      end else if (!tile_issued && retire) begin
         outstanding_nxt = outstanding - O_W'(1);
      end
   end

   // Drain exits on the retiring edge itself so done follows the last out_fire by one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = cfg_empty ? FINISH : ISSUE;
            end
         end
         ISSUE: begin
            if (tile_issued && k_wrap && n_wrap) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (outstanding_nxt == '0) begin
               state_nxt = FINISH;
            end
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         outstanding <= '0;
      end else begin
         state       <= state_nxt;
         outstanding <= outstanding_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n_tiles <= '0;
         k_tiles <= '0;
         m_cnt   <= '0;
         k_cnt   <= '0;
         n_cnt   <= '0;
         a_base  <= '0;
         a_addr  <= '0;
         b_addr  <= '0;
      end else if (start_ok) begin
         n_tiles <= bus.cfg_n_tiles;
         k_tiles <= bus.cfg_k_tiles;
         m_cnt   <= '0;
         k_cnt   <= '0;
         n_cnt   <= '0;
         a_base  <= '0;
         a_addr  <= '0;
         b_addr  <= '0;
      end else if (fire) begin
         if (!m_wrap) begin
            m_cnt  <= m_cnt + M_W'(1);
            a_addr <= a_addr + ADDR_W'(1);
            b_addr <= b_addr + ADDR_W'(k_tiles);
         end else if (!k_wrap) begin
            m_cnt  <= '0;
            k_cnt  <= k_cnt + CNT_W'(1);
            a_addr <= a_base;
            b_addr <= ADDR_W'(k_cnt) + ADDR_W'(1);
         end else begin
            m_cnt  <= '0;
            k_cnt  <= '0;
            n_cnt  <= n_cnt + CNT_W'(1);
            a_base <= a_base + A_STEP;
            a_addr <= a_base + A_STEP;
            b_addr <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c_addr <= '0;
      end else if (start_ok) begin
         c_addr <= '0;
      end else if (retire) begin
         c_addr <= c_addr + ADDR_W'(1);
      end
   end
endmodule
